// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter
// Chooses the next high-level SDRAM operation for the command issuer.
// Candidates are two requester ports (round-robin) and auto-refresh.
// Owns the refresh interval timer and the postponed-refresh count.
// One operation at a time goes out over a valid/ready/done handshake.
module sdram_access_arbiter #(
    parameter int ADDR_W           = 24,
    parameter int REFRESH_INTERVAL = 780,
    parameter int MAX_POSTPONE     = 8,
    parameter int PEND_W           = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              issue_valid,
    output logic [1:0]        issue_cmd,
    output logic [ADDR_W-1:0] issue_addr,
    output logic              issue_port,
    input  logic              issue_ready,
    input  logic              issue_done,
    output logic [PEND_W-1:0] refresh_pending,
    output logic              refresh_overrun
);

    localparam int TIMER_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX     = PEND_W'(MAX_POSTPONE);

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_REFRESH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t              r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic [PEND_W-1:0]   r_pending;
    logic                r_overrun;
    logic                r_ptr;
    logic                r_valid;
    logic [1:0]          r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_port;

    logic                w_tick;
    logic                w_handshake;
    logic                w_refDone;
    logic                w_grantPort;
    logic                w_grantWe;
    logic [ADDR_W-1:0]   w_grantAddr;

    assign w_tick      = (r_timer == '0);
    assign w_handshake = (r_state == ST_OFFER) && issue_ready;
    assign w_refDone   = w_handshake && (r_cmd == CMD_REFRESH);

    // The pointer port wins when it is requesting, otherwise the other port
    assign w_grantPort = r_ptr ? req1_valid : !req0_valid;
    assign w_grantWe   = w_grantPort ? req1_we   : req0_we;
    assign w_grantAddr = w_grantPort ? req1_addr : req0_addr;

    // Ready pulses are combinational so they land in the handshake cycle itself
    assign req0_ready      = w_handshake && (r_cmd != CMD_REFRESH) && !r_port;
    assign req1_ready      = w_handshake && (r_cmd != CMD_REFRESH) &&  r_port;
    assign issue_valid     = r_valid;
    assign issue_cmd       = r_cmd;
    assign issue_addr      = r_addr;
    assign issue_port      = r_port;
    assign refresh_pending = r_pending;
    assign refresh_overrun = r_overrun;

    // Free-running refresh interval timer; exact reload keeps the tick period at REFRESH_INTERVAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= TIMER_RELOAD;
        end else if (w_tick) begin
            r_timer <= TIMER_RELOAD;
        end else begin
            r_timer <= r_timer - TIMER_W'(1);
        end
    end

    // Pending-refresh bookkeeping: ticks add, refresh handshakes subtract, coincident events cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else if (w_tick && !w_refDone) begin
            if (r_pending >= PEND_MAX) begin
                r_overrun <= 1'b1;
            end else begin
                r_pending <= r_pending + PEND_W'(1);
            end
        end else if (w_refDone && !w_tick && (r_pending != '0)) begin
            r_pending <= r_pending - PEND_W'(1);
        end
    end

    // Selection/offer/busy sequencing with registered issuer-facing outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_valid <= 1'b0;
            r_cmd   <= CMD_NOP;
            r_addr  <= '0;
            r_port  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending >= PEND_MAX) begin
                        r_valid <= 1'b1;
                        r_cmd   <= CMD_REFRESH;
                        r_addr  <= '0;
                        r_port  <= 1'b0;
                        r_state <= ST_OFFER;
                    end else if (req0_valid || req1_valid) begin
                        r_valid <= 1'b1;
                        r_cmd   <= w_grantWe ? CMD_WRITE : CMD_READ;
                        r_addr  <= w_grantAddr;
                        r_port  <= w_grantPort;
                        r_state <= ST_OFFER;
                    end else if (r_pending != '0) begin
                        r_valid <= 1'b1;
                        r_cmd   <= CMD_REFRESH;
                        r_addr  <= '0;
                        r_port  <= 1'b0;
                        r_state <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (issue_ready) begin
                        if (r_cmd != CMD_REFRESH) begin
                            r_ptr <= !r_port;
                        end
                        r_valid <= 1'b0;
                        r_cmd   <= CMD_NOP;
                        r_addr  <= '0;
                        r_port  <= 1'b0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (issue_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb_sdram_access_arbiter
// Directed bench for sdram_access_arbiter with a short refresh interval.
// Cycle numbers count rising edges after reset release (first edge = 1).
module tb_sdram_access_arbiter;

    localparam int ADDR_W           = 24;
    localparam int REFRESH_INTERVAL = 16;
    localparam int MAX_POSTPONE     = 8;
    localparam int PEND_W           = 4;

    logic              clk;
    logic              rst;
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              issue_valid;
    logic [1:0]        issue_cmd;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_port;
    logic              issue_ready;
    logic              issue_done;
    logic [PEND_W-1:0] refresh_pending;
    logic              refresh_overrun;

    int checkCount;
    int errCount;
    int cyc;
    int refCount;

    sdram_access_arbiter #(
        .ADDR_W          (ADDR_W),
        .REFRESH_INTERVAL(REFRESH_INTERVAL),
        .MAX_POSTPONE    (MAX_POSTPONE),
        .PEND_W          (PEND_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_we        (req0_we),
        .req0_addr      (req0_addr),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_we        (req1_we),
        .req1_addr      (req1_addr),
        .req1_ready     (req1_ready),
        .issue_valid    (issue_valid),
        .issue_cmd      (issue_cmd),
        .issue_addr     (issue_addr),
        .issue_port     (issue_port),
        .issue_ready    (issue_ready),
        .issue_done     (issue_done),
        .refresh_pending(refresh_pending),
        .refresh_overrun(refresh_overrun)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Return every input to its idle value
    task automatic applyStimulus();
        req0_valid  = 1'b0;
        req0_we     = 1'b0;
        req0_addr   = '0;
        req1_valid  = 1'b0;
        req1_we     = 1'b0;
        req1_addr   = '0;
        issue_ready = 1'b0;
        issue_done  = 1'b0;
    endtask

    // Advance one rising edge and settle 2 ns past it
    task automatic stepCycle();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic gotoCycle(input int n);
        while (cyc < n) stepCycle();
    endtask

    // Assert reset for a few edges with idle inputs, release mid-cycle
    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        cyc        = 0;
        refCount   = 0;
        rst        = 1'b1;
        applyStimulus();

        // Reset state
        doReset();
        checkOutput("rst_valid",   {31'd0, issue_valid},     32'd0);
        checkOutput("rst_cmd",     {30'd0, issue_cmd},       32'd0);
        checkOutput("rst_addr",    {8'd0, issue_addr},       32'd0);
        checkOutput("rst_port",    {31'd0, issue_port},      32'd0);
        checkOutput("rst_pending", {28'd0, refresh_pending}, 32'd0);
        checkOutput("rst_overrun", {31'd0, refresh_overrun}, 32'd0);
        checkOutput("rst_ready0",  {31'd0, req0_ready},      32'd0);
        checkOutput("rst_ready1",  {31'd0, req1_ready},      32'd0);

        // First refresh tick and opportunistic refresh
        gotoCycle(15);
        checkOutput("t1_pend15", {28'd0, refresh_pending}, 32'd0);
        gotoCycle(16);
        checkOutput("t1_pend16",  {28'd0, refresh_pending}, 32'd1);
        checkOutput("t1_valid16", {31'd0, issue_valid},     32'd0);
        gotoCycle(17);
        checkOutput("t1_valid17", {31'd0, issue_valid}, 32'd1);
        checkOutput("t1_cmd17",   {30'd0, issue_cmd},   32'd3);
        checkOutput("t1_addr17",  {8'd0, issue_addr},   32'd0);
        issue_ready = 1'b1;
        #1;
        checkOutput("t1_rdy0_ref", {31'd0, req0_ready}, 32'd0);
        checkOutput("t1_rdy1_ref", {31'd0, req1_ready}, 32'd0);
        gotoCycle(18);
        checkOutput("t1_pend18",  {28'd0, refresh_pending}, 32'd0);
        checkOutput("t1_valid18", {31'd0, issue_valid},     32'd0);
        checkOutput("t1_cmd18",   {30'd0, issue_cmd},       32'd0);
        issue_ready = 1'b0;
        gotoCycle(21);
        issue_done = 1'b1;
        gotoCycle(22);
        issue_done = 1'b0;
        gotoCycle(31);
        checkOutput("t1_pend31",  {28'd0, refresh_pending}, 32'd0);
        checkOutput("t1_valid31", {31'd0, issue_valid},     32'd0);
        gotoCycle(32);
        checkOutput("t1_pend32", {28'd0, refresh_pending}, 32'd1);

        // Round-robin alternation with both ports requesting continuously
        doReset();
        req0_valid  = 1'b1;
        req0_we     = 1'b0;
        req0_addr   = 24'h0000A0;
        req1_valid  = 1'b1;
        req1_we     = 1'b1;
        req1_addr   = 24'h0111B1;
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gotoCycle(1 + 4 * k);
            checkOutput("t2_valid", {31'd0, issue_valid}, 32'd1);
            checkOutput("t2_port",  {31'd0, issue_port},  (k % 2));
            checkOutput("t2_cmd",   {30'd0, issue_cmd},   (k % 2 == 1) ? 32'd2 : 32'd1);
            checkOutput("t2_addr",  {8'd0, issue_addr},   (k % 2 == 1) ? 32'h0111B1 : 32'h0000A0);
            checkOutput("t2_rdy0",  {31'd0, req0_ready},  (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("t2_rdy1",  {31'd0, req1_ready},  (k % 2 == 1) ? 32'd1 : 32'd0);
            gotoCycle(2 + 4 * k);
            checkOutput("t2_rdy0_pulse", {31'd0, req0_ready},  32'd0);
            checkOutput("t2_rdy1_pulse", {31'd0, req1_ready},  32'd0);
            checkOutput("t2_busy_valid", {31'd0, issue_valid}, 32'd0);
            gotoCycle(3 + 4 * k);
            issue_done = 1'b1;
            gotoCycle(4 + 4 * k);
            issue_done = 1'b0;
        end

        // Saturation, overrun and urgent refresh ahead of a waiting port
        doReset();
        req0_valid  = 1'b1;
        req0_we     = 1'b0;
        req0_addr   = 24'h00C0DE;
        issue_ready = 1'b1;
        gotoCycle(1);
        checkOutput("t3_cmd1", {30'd0, issue_cmd}, 32'd1);
        gotoCycle(2);
        checkOutput("t3_busy", {31'd0, issue_valid}, 32'd0);
        req0_valid  = 1'b0;
        issue_ready = 1'b0;
        req1_valid  = 1'b1;
        req1_we     = 1'b1;
        req1_addr   = 24'h0BEEF1;
        gotoCycle(143);
        checkOutput("t3_pend143", {28'd0, refresh_pending}, 32'd8);
        checkOutput("t3_ovr143",  {31'd0, refresh_overrun}, 32'd0);
        gotoCycle(144);
        checkOutput("t3_pend144", {28'd0, refresh_pending}, 32'd8);
        checkOutput("t3_ovr144",  {31'd0, refresh_overrun}, 32'd1);
        gotoCycle(145);
        issue_done = 1'b1;
        gotoCycle(146);
        issue_done  = 1'b0;
        issue_ready = 1'b1;
        gotoCycle(147);
        checkOutput("t3_urg_valid", {31'd0, issue_valid}, 32'd1);
        checkOutput("t3_urg_cmd",   {30'd0, issue_cmd},   32'd3);
        checkOutput("t3_urg_rdy1",  {31'd0, req1_ready},  32'd0);
        gotoCycle(148);
        checkOutput("t3_pend148", {28'd0, refresh_pending}, 32'd7);
        gotoCycle(149);
        issue_done = 1'b1;
        gotoCycle(150);
        issue_done = 1'b0;
        gotoCycle(151);
        checkOutput("t3_p1_cmd",  {30'd0, issue_cmd},  32'd2);
        checkOutput("t3_p1_port", {31'd0, issue_port}, 32'd1);
        checkOutput("t3_p1_addr", {8'd0, issue_addr},  32'h0BEEF1);
        checkOutput("t3_p1_rdy1", {31'd0, req1_ready}, 32'd1);
        gotoCycle(152);
        req1_valid = 1'b0;
        issue_done = 1'b1;
        while (cyc < 180) begin
            if (issue_valid && issue_ready && (issue_cmd == 2'b11)) refCount++;
            stepCycle();
        end
        checkOutput("t3_ref_count", refCount, 32'd9);
        gotoCycle(181);
        checkOutput("t3_pend181",  {28'd0, refresh_pending}, 32'd0);
        checkOutput("t3_ovr_stick", {31'd0, refresh_overrun}, 32'd1);
        gotoCycle(182);
        checkOutput("t3_idle182", {31'd0, issue_valid}, 32'd0);
        issue_done = 1'b0;

        // Non-urgent pending loses to a port; tick coincident with a refresh handshake
        doReset();
        gotoCycle(17);
        checkOutput("t4_cmd17", {30'd0, issue_cmd}, 32'd3);
        gotoCycle(64);
        checkOutput("t4_pend64",  {28'd0, refresh_pending}, 32'd4);
        checkOutput("t4_hold64",  {31'd0, issue_valid},     32'd1);
        issue_ready = 1'b1;
        gotoCycle(65);
        checkOutput("t4_pend65", {28'd0, refresh_pending}, 32'd3);
        req0_valid = 1'b1;
        req0_we    = 1'b1;
        req0_addr  = 24'h00A5A5;
        issue_done = 1'b1;
        gotoCycle(66);
        issue_done = 1'b0;
        gotoCycle(67);
        checkOutput("t4_cmd67",  {30'd0, issue_cmd},       32'd2);
        checkOutput("t4_port67", {31'd0, issue_port},      32'd0);
        checkOutput("t4_addr67", {8'd0, issue_addr},       32'h00A5A5);
        checkOutput("t4_pend67", {28'd0, refresh_pending}, 32'd3);
        checkOutput("t4_rdy067", {31'd0, req0_ready},      32'd1);
        gotoCycle(68);
        req0_valid = 1'b0;
        issue_done = 1'b1;
        gotoCycle(69);
        issue_done = 1'b0;
        gotoCycle(70);
        checkOutput("t4_cmd70", {30'd0, issue_cmd}, 32'd3);
        gotoCycle(71);
        checkOutput("t4_pend71", {28'd0, refresh_pending}, 32'd2);
        issue_ready = 1'b0;
        issue_done  = 1'b1;
        gotoCycle(72);
        issue_done = 1'b0;
        gotoCycle(73);
        checkOutput("t4_cmd73", {30'd0, issue_cmd}, 32'd3);
        gotoCycle(79);
        checkOutput("t4_pend79", {28'd0, refresh_pending}, 32'd2);
        issue_ready = 1'b1;
        gotoCycle(80);
        checkOutput("t4_pend80",  {28'd0, refresh_pending}, 32'd2);
        checkOutput("t4_valid80", {31'd0, issue_valid},     32'd0);

        // Reset asserted while an offer is outstanding
        doReset();
        req0_valid = 1'b1;
        req0_addr  = 24'h123456;
        gotoCycle(1);
        checkOutput("t5_offer", {31'd0, issue_valid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_valid", {31'd0, issue_valid}, 32'd0);
        checkOutput("t5_cmd",   {30'd0, issue_cmd},   32'd0);
        checkOutput("t5_addr",  {8'd0, issue_addr},   32'd0);
        issue_ready = 1'b1;
        #1;
        checkOutput("t5_rdy0", {31'd0, req0_ready}, 32'd0);
        doReset();
        gotoCycle(15);
        checkOutput("t5_pend15", {28'd0, refresh_pending}, 32'd0);
        gotoCycle(16);
        checkOutput("t5_pend16", {28'd0, refresh_pending}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
